// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the 6502-style single-port memory bus
// and the mem_copy_master bus initiator.
//   ADDR_W / DATA_W  default bus address and data widths
//   state_t          copy-engine sequencer states
//   RW_READ/RW_WRITE encodings of the bus rW line
package mem_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/mem_copy_master.sv
// mem_copy_master: byte-serial memory copy engine for the single-port bus.
// On an accepted start it copies len bytes from src to dst using alternating
// READ and WRITE bus cycles, then pulses done for one cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               command strobe (sampled only in IDLE)
//   src, dst, len       command operands, captured on accepted start
//   fill, fill_value    fill-mode select and fill byte, captured on start
//   busy, done          status: busy while not IDLE, done is a 1-cycle pulse
//   mem_addr, mem_rW,
//   mem_wdata           bus outputs (decoded from state/registers only)
//   mem_rdata           bus read data, combinational in the same cycle
//
// Build option: define MEM_COPY_FILL_EN to enable fill mode, where READ
// cycles are skipped and every WRITE drives the captured fill byte. Without
// it the fill inputs are ignored and every command is a copy.
module mem_copy_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = mem_bus_pkg::ADDR_W,
    parameter int DATA_W = mem_bus_pkg::DATA_W,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rW,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] hold;
    logic              fill_mode;

`ifdef MEM_COPY_FILL_EN
    logic fill_mode_q;
    assign fill_mode = fill_mode_q;
`else
    // Fill inputs are part of the interface but have no effect in this build.
    logic unused_fill;
    assign unused_fill = ^{fill, fill_value};
    assign fill_mode   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            hold      <= '0;
`ifdef MEM_COPY_FILL_EN
            fill_mode_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    src_ptr   <= src;
                    dst_ptr   <= dst;
                    remaining <= len;
`ifdef MEM_COPY_FILL_EN
                    fill_mode_q <= fill;
                    // In fill mode the hold register simply carries the
                    // fill byte, so WRITE needs no extra data mux.
                    if (fill) hold <= fill_value;
`endif
                end
                READ:  hold <= mem_rdata;
                WRITE: begin
                    src_ptr   <= src_ptr + ADDR_W'(1);
                    dst_ptr   <= dst_ptr + ADDR_W'(1);
                    remaining <= remaining - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) begin
                if (len == '0)
                    state_nxt = DONE;
`ifdef MEM_COPY_FILL_EN
                else if (fill)
                    state_nxt = WRITE;
`endif
                else
                    state_nxt = READ;
            end
            READ:  state_nxt = WRITE;
            WRITE: begin
                if (remaining == LEN_W'(1)) state_nxt = DONE;
                else if (fill_mode)         state_nxt = WRITE;
                else                        state_nxt = READ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs depend only on registered state, never on start, so the
    // write strobe is low only while the state register holds WRITE (and the
    // async reset forces IDLE, keeping rW high during reset).
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        mem_rW    = RW_READ;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            READ:  mem_addr = src_ptr;
            WRITE: begin
                mem_addr  = dst_ptr;
                mem_rW    = RW_WRITE;
                mem_wdata = hold;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_master.sv
// Self-checking bench for mem_copy_master: behavioural 64 KiB memory, a
// sequential reference model that pushes expected bus cycles to a queue, and
// a negedge monitor that pops and compares them against the DUT bus.
module tb_mem_copy_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src = '0, dst = '0, len = '0;
    logic        fill = 1'b0;
    logic [7:0]  fill_value = '0;
    logic        busy, done, mem_rW;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_t;

    bus_t q[$];

    logic [7:0] mem  [0:65535];
    logic [7:0] refm [0:65535];

    always #5 clk = ~clk;

    mem_copy_master dut (
        .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
        .fill(fill), .fill_value(fill_value), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rW(mem_rW), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    function automatic logic [7:0] init_val(input logic [15:0] a);
        case (a)
            16'h0200: return 8'h11;
            16'h0201: return 8'h22;
            16'h0202: return 8'h33;
            16'h0203: return 8'h44;
            16'h0400: return 8'hAA;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    // Memory: sole writer of mem; writes land on the rising edge.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
        forever begin
            @(posedge clk);
            if (mem_rW === 1'b0) mem[mem_addr] = mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: ascending byte-serial copy (or fill), one bus cycle per entry.
    task automatic model(input logic [15:0] s, input logic [15:0] d, input int n,
                         input logic f, input logic [7:0] fv);
        logic [15:0] sa, da;
        logic [7:0]  b;
        for (int i = 0; i < n; i++) begin
            sa = s + 16'(i);
            da = d + 16'(i);
`ifdef MEM_COPY_FILL_EN
            if (f) b = fv;
            else begin
                q.push_back('{1'b1, sa, 8'h00});
                b = refm[sa];
            end
`else
            q.push_back('{1'b1, sa, 8'h00});
            b = refm[sa];
`endif
            q.push_back('{1'b0, da, b});
            refm[da] = b;
        end
    endtask

    task automatic check_mem(input string tag, input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++)
            chk(tag, {24'h0, mem[base + 16'(i)]}, {24'h0, refm[base + 16'(i)]});
    endtask

    task automatic poke();
        start = 1'b1; src = 16'hBEEF; dst = 16'h0000; len = 16'd1; fill = ~fill;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Issue a command and track it to done (or abort it with reset).
    task automatic run(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                       input logic f, input logic [7:0] fv, input int exp_cyc,
                       input int poke_at, input int abort_at);
        int cyc, busy_n;
        bit got_done;
        if (abort_at == 0) model(s, d, int'(n), f, fv);
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = n; fill = f; fill_value = fv;
        @(posedge clk);
        #1;
        start = 1'b0; src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
        fill_value = 8'($urandom);
        cyc = 0; busy_n = 0; got_done = 0;
        while (!got_done && cyc < exp_cyc + 5) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                got_done = 1;
                chk("done_rw", {31'h0, mem_rW}, 32'h1);
            end
            if (abort_at > 0 && cyc == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_busy", {31'h0, busy}, 32'h0);
                chk("abort_rw", {31'h0, mem_rW}, 32'h1);
                chk("abort_q", q.size(), 32'h0);
                repeat (2) begin
                    @(negedge clk);
                    chk("abort_done", {31'h0, done}, 32'h0);
                end
                rst = 1'b0;
                return;
            end
            if (poke_at > 0 && (cyc == poke_at || got_done)) poke();
        end
        chk("done_seen", {31'h0, got_done}, 32'h1);
        chk("done_lat", cyc, exp_cyc);
        chk("busy_cycles", busy_n, exp_cyc);
        chk("q_drained", q.size(), 32'h0);
        @(negedge clk);
        chk("idle_busy", {31'h0, busy}, 32'h0);
        chk("done_pulse", {31'h0, done}, 32'h0);
    endtask

    // Bus monitor: every READ/WRITE cycle must match the next expected entry.
    always @(negedge clk) begin
        bus_t t;
        if (rst === 1'b0) begin
            if (busy === 1'b1 && done === 1'b0) begin
                chk("bus_expected", {31'h0, q.size() > 0}, 32'h1);
                if (q.size() > 0) begin
                    t = q.pop_front();
                    chk("bus_rw", {31'h0, mem_rW}, {31'h0, t.rw});
                    chk("bus_addr", {16'h0, mem_addr}, {16'h0, t.addr});
                    if (!t.rw) chk("bus_wdata", {24'h0, mem_wdata}, {24'h0, t.data});
                end
            end else if (busy === 1'b0) begin
                chk("idle_rw", {31'h0, mem_rW}, 32'h1);
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) refm[i] = init_val(16'(i));

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_rw", {31'h0, mem_rW}, 32'h1);
        chk("rst_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_wdata", {24'h0, mem_wdata}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 4-byte copy; starts while busy and in DONE are ignored
        run(16'h0200, 16'h0300, 16'd4, 1'b0, 8'h00, 9, 3, 0);
        chk("cp0", {24'h0, mem[16'h0300]}, 32'h11);
        chk("cp1", {24'h0, mem[16'h0301]}, 32'h22);
        chk("cp2", {24'h0, mem[16'h0302]}, 32'h33);
        chk("cp3", {24'h0, mem[16'h0303]}, 32'h44);
        chk("cp_beef_dst0", {24'h0, mem[16'h0000]}, {24'h0, init_val(16'h0000)});

        // Empty command: done next cycle, no bus cycles
        run(16'h0800, 16'h0900, 16'd0, 1'b0, 8'h00, 1, 1, 0);
        check_mem("len0_mem", 16'h0900, 4);

        // Source pointer wraps through 0xFFFF
        run(16'hFFFE, 16'h1000, 16'd4, 1'b0, 8'h00, 9, 0, 0);
        check_mem("wrap_mem", 16'h1000, 4);

        // Overlapping ascending copy replicates the first byte
        run(16'h0400, 16'h0401, 16'd3, 1'b0, 8'h00, 7, 0, 0);
        chk("ovl1", {24'h0, mem[16'h0401]}, 32'hAA);
        chk("ovl2", {24'h0, mem[16'h0402]}, 32'hAA);
        chk("ovl3", {24'h0, mem[16'h0403]}, 32'hAA);

        // Reset during the third WRITE of an 8-byte copy
        model(16'h0600, 16'h0700, 2, 1'b0, 8'h00);
        q.push_back('{1'b1, 16'h0602, 8'h00});
        q.push_back('{1'b0, 16'h0702, refm[16'h0602]});
        run(16'h0600, 16'h0700, 16'd8, 1'b0, 8'h00, 17, 3, 6);
        check_mem("abort_mem", 16'h0700, 3);
        chk("abort_b2", {24'h0, mem[16'h0702]}, {24'h0, init_val(16'h0702)});
        @(negedge clk);

        // Fill command (a plain copy when fill mode is not built in)
`ifdef MEM_COPY_FILL_EN
        run(16'h2000, 16'h0500, 16'd16, 1'b1, 8'h00, 17, 0, 0);
        chk("fill0", {24'h0, mem[16'h0500]}, 32'h0);
        chk("fillF", {24'h0, mem[16'h050F]}, 32'h0);
`else
        run(16'h2000, 16'h0500, 16'd16, 1'b1, 8'h00, 33, 0, 0);
`endif
        check_mem("fill_mem", 16'h0500, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Bus initiator for the 6502-style single-port memory bus: address[15:0], rW (1=read, 0=write), write data, combinational read data.
- On command, copies LEN bytes from SRC to DST, one byte at a time, using alternating read and write cycles.
- Used by the test harness and boot logic to relocate program images and to preload or clear RAM without involving the CPU.
- Occupies the memory's master port while busy; an external mux selects between it and the CPU.

Parameters:
- ADDR_W, 16, bus address width; all address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8, bus data width.
- LEN_W, 16, width of the byte-count input.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- src  in  ADDR_W  source base address; captured on accepted start.
- dst  in  ADDR_W  destination base address; captured on accepted start.
- len  in  LEN_W  byte count; captured on accepted start.
- fill  in  1  fill-mode select; captured on start; used only with the optional feature.
- fill_value  in  DATA_W  fill byte; captured on start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a command completes.
- mem_addr  out  ADDR_W  bus address.
- mem_rW  out  1  bus read/write-complement.
- mem_wdata  out  DATA_W  bus write data.
- mem_rdata  in  DATA_W  bus read data, valid combinationally in the same cycle as mem_addr.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, mem_rW=1, mem_addr=0, mem_wdata=0, all counters and holding registers 0.
- mem_rW must never be 0 outside the WRITE state, including during reset, so no spurious write reaches memory.
- States:
  - IDLE: mem_rW=1. On start=1, capture src, dst, len and fill fields. If len==0, go to DONE; otherwise go to READ.
  - READ: mem_addr=src_ptr, mem_rW=1. At the clock edge, latch mem_rdata into hold, then go to WRITE.
  - WRITE: mem_addr=dst_ptr, mem_rW=0, mem_wdata=hold. At the edge, increment src_ptr and dst_ptr (wrapping), decrement remaining. If remaining was 1, go to DONE; else go to READ.
  - DONE: done=1 for exactly one cycle, busy=1, mem_rW=1. Next state is IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from start to the bus.
- Latency:
  - Accepted start with len=N>0: first READ cycle is the next cycle, 2N bus cycles follow, then done one cycle after the final WRITE.
  - Total from the start edge to the done cycle: 2N+1 cycles.
  - len=0: done occurs in the cycle after start, with no bus cycles.
- start while busy (including in DONE) is ignored, and the captured operands do not change.
- Address wrap: a pointer at 0xFFFF increments to 0x0000. No error is raised.
- Overlap: the copy is strictly ascending and byte-serial. If dst==src+1, every destination byte receives the original byte at src. This is defined behaviour, not an error.
- Length: len up to 2^LEN_W-1 is supported. len=0 is the only empty case.
- Reset mid-operation: the block returns to IDLE immediately (asynchronously) with mem_rW=1. The partial copy is abandoned and done is not pulsed.

Optional Feature:
- Macro: MEM_COPY_FILL_EN.
- Defined: when fill was captured as 1, READ states are skipped. Each WRITE drives fill_value. Len N takes N write cycles, and done follows N+1 cycles after start.
- Not defined: the fill and fill_value ports remain on the interface but are ignored, and every command is a copy.

Decomposition:
- Package mem_bus_pkg:
  - ADDR_W and DATA_W constants.
  - state enum {IDLE, READ, WRITE, DONE}.
  - RW_READ=1 and RW_WRITE=0 constants.
- Single flat module: FSM plus two pointer registers, a remaining counter and the hold register. No sub-module is warranted.

Test Plan:
- Preload 0x0200..0x0203 = 11,22,33,44; start src=0x0200, dst=0x0300, len=4 -> 0x0300..0x0303 = 11,22,33,44; done exactly 9 cycles after the start edge; busy high for 9 cycles; mem_rW pattern 1,0 repeated 4 times.
- start with len=0 -> done the next cycle; mem_rW stays 1 throughout; memory unchanged.
- src=0xFFFE, dst=0x1000, len=4 -> reads from 0xFFFE, 0xFFFF, 0x0000, 0x0001; bytes land at 0x1000..0x1003.
- Overlap: 0x0400=0xAA, src=0x0400, dst=0x0401, len=3 -> 0x0401..0x0403 all equal 0xAA.
- Assert rst during the third WRITE of an 8-byte copy -> busy=0 and mem_rW=1 immediately; no done pulse; bytes 0-1 copied, byte 2 of the destination unchanged; start pulses issued while busy are ignored.
- With MEM_COPY_FILL_EN defined: fill=1, fill_value=0x00, dst=0x0500, len=16 -> 16 consecutive write cycles with no read cycles, 0x0500..0x050F cleared, done 17 cycles after start.
